// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: LC-3b datapath types and default register file geometry
package regfile_sb_pkg;
  typedef logic [15:0] lc3b_word;
  typedef logic [2:0] lc3b_reg;
  localparam int REGFILE_DEPTH = 8;
  localparam int REGFILE_RD_PORTS = 3;
endpackage

// File: rtl/sb_busy_bits.sv
// sb_busy_bits: per-register busy flags with flush > issue > writeback priority and a registered popcount
module sb_busy_bits
  import regfile_sb_pkg::*;
#(
  parameter int DEPTH = REGFILE_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [AW-1:0] dest,
  input  logic          issue,
  input  logic [AW-1:0] issue_dest,
  input  logic          flush,
  output logic [DEPTH-1:0] busy_vec,
  output logic [CW-1:0]    pending_cnt
);
  logic [DEPTH-1:0] busy_nxt;
  logic [CW-1:0] cnt_nxt;
  // A new producer issuing to r outranks a same-cycle writeback of the old one.
  always_comb begin
    busy_nxt = busy_vec;
    cnt_nxt = '0;
    for (int r = 0; r < DEPTH; r++) begin
      busy_nxt[r] = flush ? 1'b0 :
                    (issue && issue_dest == AW'(r)) ? 1'b1 :
                    (load && dest == AW'(r)) ? 1'b0 : busy_vec[r];
      cnt_nxt = cnt_nxt + CW'(busy_nxt[r]);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_vec <= '0;
      pending_cnt <= '0;
    end else begin
      busy_vec <= busy_nxt;
      pending_cnt <= cnt_nxt;
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with write-to-read bypass and busy-bit scoreboard
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int WIDTH = $bits(lc3b_word),
  parameter int DEPTH = REGFILE_DEPTH,
  parameter int NUM_RD = REGFILE_RD_PORTS,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [AW-1:0]           dest,
  input  logic [WIDTH-1:0]        data_in,
  input  logic [NUM_RD*AW-1:0]    src,
  output logic [NUM_RD*WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]       rd_busy,
  input  logic                    issue,
  input  logic [AW-1:0]           issue_dest,
  input  logic                    flush,
  output logic [DEPTH-1:0]        busy_vec,
  output logic [CW-1:0]           pending_cnt
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else if (load) begin
      mem[dest] <= data_in;
    end
  end
  sb_busy_bits #(.DEPTH(DEPTH)) u_busy (
    .clk(clk),
    .reset(reset),
    .load(load),
    .dest(dest),
    .issue(issue),
    .issue_dest(issue_dest),
    .flush(flush),
    .busy_vec(busy_vec),
    .pending_cnt(pending_cnt)
  );
  // A writeback landing this cycle both supplies the operand and resolves its hazard.
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0] s;
    logic hit;
    assign s = src[g*AW +: AW];
    assign hit = load && dest == s;
    assign rdata[g*WIDTH +: WIDTH] = reset ? '0 : hit ? data_in : mem[s];
    assign rd_busy[g] = busy_vec[s] && !hit;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks on the default instance, randomized model comparison on a wide instance
module tb_regfile_sb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        a_load = 1'b0, a_issue = 1'b0, a_flush = 1'b0;
  logic [2:0]  a_dest = '0, a_issue_dest = '0;
  logic [15:0] a_data_in = '0;
  logic [8:0]  a_src = '0;
  logic [47:0] a_rdata;
  logic [2:0]  a_rd_busy;
  logic [7:0]  a_busy_vec;
  logic [3:0]  a_pending_cnt;

  logic         b_load = 1'b0, b_issue = 1'b0, b_flush = 1'b0;
  logic [3:0]   b_dest = '0, b_issue_dest = '0;
  logic [31:0]  b_data_in = '0;
  logic [15:0]  b_src = '0;
  logic [127:0] b_rdata;
  logic [3:0]   b_rd_busy;
  logic [15:0]  b_busy_vec;
  logic [4:0]   b_pending_cnt;

  regfile_sb dut_a (
    .clk(clk), .reset(reset), .load(a_load), .dest(a_dest), .data_in(a_data_in),
    .src(a_src), .rdata(a_rdata), .rd_busy(a_rd_busy), .issue(a_issue),
    .issue_dest(a_issue_dest), .flush(a_flush), .busy_vec(a_busy_vec),
    .pending_cnt(a_pending_cnt)
  );

  regfile_sb #(.WIDTH(32), .DEPTH(16), .NUM_RD(4)) dut_b (
    .clk(clk), .reset(reset), .load(b_load), .dest(b_dest), .data_in(b_data_in),
    .src(b_src), .rdata(b_rdata), .rd_busy(b_rd_busy), .issue(b_issue),
    .issue_dest(b_issue_dest), .flush(b_flush), .busy_vec(b_busy_vec),
    .pending_cnt(b_pending_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] m_data [16];
  logic [15:0] m_busy;

  initial begin
    // reset held: outputs forced to zero even with a bypassing write present
    a_load = 1'b1; a_dest = 3'd0; a_data_in = 16'hFFFF; a_src = '0;
    #3;
    check("reset_rdata", 64'(a_rdata), 64'(0));
    check("reset_busy", 64'(a_busy_vec), 64'(0));
    check("reset_cnt", 64'(a_pending_cnt), 64'(0));
    a_load = 1'b0;
    #5 reset = 1'b0;
    tick();

    // bypass then stored value
    a_load = 1'b1; a_dest = 3'd3; a_data_in = 16'hBEEF; a_src = {3'd0, 3'd0, 3'd3};
    #2 check("bypass_rd0", 64'(a_rdata[15:0]), 64'(16'hBEEF));
    tick();
    a_load = 1'b0;
    #2 check("stored_rd0", 64'(a_rdata[15:0]), 64'(16'hBEEF));

    // issue then resolving writeback
    a_issue = 1'b1; a_issue_dest = 3'd5;
    tick();
    a_issue = 1'b0; a_src = {3'd0, 3'd5, 3'd3};
    #2;
    check("issue_busy", 64'(a_busy_vec), 64'(8'h20));
    check("issue_cnt", 64'(a_pending_cnt), 64'(1));
    check("issue_rdbusy1", 64'(a_rd_busy[1]), 64'(1));
    a_load = 1'b1; a_dest = 3'd5; a_data_in = 16'h0042;
    #1;
    check("wb_rdbusy1", 64'(a_rd_busy[1]), 64'(0));
    check("wb_bypass1", 64'(a_rdata[31:16]), 64'(16'h0042));
    check("wb_busy_hold", 64'(a_busy_vec), 64'(8'h20));
    tick();
    a_load = 1'b0;
    #2;
    check("wb_busy_clr", 64'(a_busy_vec), 64'(0));
    check("wb_cnt_clr", 64'(a_pending_cnt), 64'(0));

    // issue and load to the same busy register in one cycle
    a_issue = 1'b1; a_issue_dest = 3'd2;
    tick();
    a_load = 1'b1; a_dest = 3'd2; a_data_in = 16'h1234;
    tick();
    a_issue = 1'b0; a_load = 1'b0; a_src = {3'd2, 3'd5, 3'd3};
    #2;
    check("waw_busy", 64'(a_busy_vec), 64'(8'h04));
    check("waw_cnt", 64'(a_pending_cnt), 64'(1));
    check("waw_data", 64'(a_rdata[47:32]), 64'(16'h1234));
    check("waw_rdbusy2", 64'(a_rd_busy), 64'(3'b100));

    // fill seven registers (2 already busy), then flush beats issue and load
    for (int r = 1; r < 8; r++) begin
      a_issue = 1'b1; a_issue_dest = 3'(r);
      tick();
    end
    a_issue = 1'b0;
    #2;
    check("fill_busy", 64'(a_busy_vec), 64'(8'hFE));
    check("fill_cnt", 64'(a_pending_cnt), 64'(7));
    a_flush = 1'b1; a_issue = 1'b1; a_issue_dest = 3'd0;
    a_load = 1'b1; a_dest = 3'd6; a_data_in = 16'h0606;
    tick();
    a_flush = 1'b0; a_issue = 1'b0; a_load = 1'b0;
    #2;
    check("flush_busy", 64'(a_busy_vec), 64'(0));
    check("flush_cnt", 64'(a_pending_cnt), 64'(0));

    // asynchronous reset mid-run wipes data and scoreboard at once
    a_issue = 1'b1; a_issue_dest = 3'd4;
    tick();
    a_issue = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("areset_rdata", 64'(a_rdata), 64'(0));
    check("areset_busy", 64'(a_busy_vec), 64'(0));
    check("areset_cnt", 64'(a_pending_cnt), 64'(0));
    check("areset_rdbusy", 64'(a_rd_busy), 64'(0));
    tick();
    reset = 1'b0;
    tick();
    #2;
    check("post_reset_rdata", 64'(a_rdata), 64'(0));
    check("post_reset_busy", 64'(a_busy_vec), 64'(0));

    // random run on the wide instance against a behavioural model
    for (int r = 0; r < 16; r++) m_data[r] = '0;
    m_busy = '0;
    for (int c = 0; c < 10000; c++) begin
      b_load = $urandom_range(0, 2) != 0;
      b_dest = 4'($urandom_range(0, 15));
      b_data_in = $urandom;
      b_issue = $urandom_range(0, 2) == 0;
      b_issue_dest = 4'($urandom_range(0, 15));
      b_flush = $urandom_range(0, 31) == 0;
      for (int i = 0; i < 4; i++)
        b_src[i*4 +: 4] = ($urandom_range(0, 3) == 0) ? b_dest : 4'($urandom_range(0, 15));
      #2;
      for (int i = 0; i < 4; i++) begin
        logic [3:0] s;
        logic hit;
        s = b_src[i*4 +: 4];
        hit = b_load && (b_dest == s);
        check("rand_rdata", 64'(b_rdata[i*32 +: 32]), 64'(hit ? b_data_in : m_data[s]));
        check("rand_rdbusy", 64'(b_rd_busy[i]), 64'(m_busy[s] && !hit));
      end
      check("rand_busy", 64'(b_busy_vec), 64'(m_busy));
      check("rand_cnt", 64'(b_pending_cnt), 64'($countones(m_busy)));
      if (b_load) m_data[b_dest] = b_data_in;
      if (b_flush) m_busy = '0;
      else begin
        if (b_load) m_busy[b_dest] = 1'b0;
        if (b_issue) m_busy[b_issue_dest] = 1'b1;
      end
      tick();
    end
    b_load = 1'b0; b_issue = 1'b0; b_flush = 1'b0;
    #2;
    check("final_busy", 64'(b_busy_vec), 64'(m_busy));
    check("final_cnt", 64'(b_pending_cnt), 64'($countones(m_busy)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
